muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers for the pipelined core.
//  Sits beside the EX-stage ALU. Supports signed and unsigned MULT/DIV at a parametrised width.
//  Produces a busy flag that the hazard logic ORs into its stall condition.
//  Supports abort on pipeline flush and direct HI/LO writes (MTHI/MTLO).
// PARAMETERS
//  DATA_W  32  operand width, and width of each of HI and LO; must be >= 4
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > DATA_W
// PORTS
//  clk       in   1       rising-edge clock; single clock domain
//  rst       in   1       asynchronous reset, active-low
//  start     in   1       launch operation; sampled only while busy=0
//  op        in   2       00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a         in   DATA_W  multiplicand / dividend
//  b         in   DATA_W  multiplier / divisor
//  cancel    in   1       flush: abort any operation in flight
//  hilo_we   in   2       [1] write HI, [0] write LO, from wdata
//  wdata     in   DATA_W  MTHI/MTLO data
//  busy      out  1       operation in flight
//  done      out  1       one-cycle pulse when a result is committed to HI/LO
//  div0      out  1       sticky flag: last committed divide had b=0
//  hi        out  DATA_W  HI register
//  lo        out  DATA_W  LO register
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; hi=lo=0; busy=done=div0=0. Any operation in flight is lost.
//  FSM states and transitions:
//   IDLE -> RUN on start & !cancel. op, a and b are latched; later input changes are ignored.
//   RUN: exactly DATA_W cycles, one radix-2 step per cycle (shift-add multiply, restoring divide).
//        Signed ops work on magnitudes. RUN -> FIX after DATA_W cycles.
//   FIX: one cycle for sign correction; HI/LO are written at the end of this cycle. FIX -> DONE.
//   DONE: one cycle, done=1. DONE -> IDLE.
//  Timing: with start high in cycle 0, RUN occupies cycles 1..DATA_W, FIX is cycle DATA_W+1,
//   and done=1 in cycle DATA_W+2 with the new hi/lo visible.
//  busy = (state != IDLE), i.e. high in cycles 1..DATA_W+2.
//   A start while busy=1 is ignored; it is not queued.
//  Multiply result: {hi,lo} = full 2*DATA_W-bit product.
//   For MULT the product is the two's-complement signed product.
//  Divide result: lo = quotient truncated toward zero; hi = remainder.
//   For signed divide the remainder takes the sign of the dividend.
//  DIV of the most-negative value by -1: lo = most-negative value, hi = 0. No flag.
//  Divide by zero (DIVU or DIV): lo = all ones, hi = latched a, div0 = 1.
//   div0 is updated on every committed divide; it is cleared by a divide with b!=0.
//   Multiplies leave div0 unchanged.
//  cancel=1 in any state: next state is IDLE; hi/lo/div0 are unchanged and no done pulse occurs.
//   cancel takes priority over start in the same cycle.
//   A cancel in FIX suppresses the HI/LO write.
//  hilo_we: honoured only while busy=0 and start=0. It writes the selected register(s) at the
//   clock edge. It is ignored otherwise. A start in the same cycle wins and the write is dropped.
//  All outputs are registered; there are no combinational paths from inputs to outputs.
// TESTING
//  1 DATA_W=32, MULTU a=FFFFFFFF b=FFFFFFFF -> busy cycles 1..34, done in cycle 34, hi=FFFFFFFE lo=00000001.
//  2 MULT a=FFFFFFFD(-3) b=00000007 -> hi=FFFFFFFF lo=FFFFFFEB. DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF.
//  3 DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0, div0=0. DIVU a=5 b=0 -> lo=FFFFFFFF hi=5, div0=1.
//  4 Start MULTU, cancel in cycle 10 -> busy=0 in cycle 11, no done, hi/lo keep prior values.
//    A start pulse in cycle 5 is ignored.
//  5 Idle hilo_we=2'b11 wdata=1234 -> hi=lo=1234 next cycle. The same write while busy -> no change.
//  6 DATA_W=8: MULTU FF*FF -> hi=FE lo=01, done in cycle 10. rst low mid-RUN -> busy/done/hi/lo=0 at once.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Sits beside the EX-stage ALU. It runs one radix-2 step per cycle: shift-add for
// multiply and restoring division for divide. Signed operations work on operand
// magnitudes, and the signs are corrected in a single FIX cycle before HI/LO commit.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active-low
//   start    launch operation (sampled only while busy=0)
//   op       00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b     multiplicand/dividend, multiplier/divisor
//   cancel   pipeline flush: abort any operation in flight, no commit
//   hilo_we  [1] write HI, [0] write LO from wdata (idle and no start only)
//   wdata    MTHI/MTLO data
//   busy     operation in flight (state != IDLE)
//   done     one-cycle pulse while the freshly committed HI/LO are visible
//   div0     sticky: last committed divide had a zero divisor
//   hi, lo   architectural HI/LO registers
module muldiv_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cancel,
    input  logic [1:0]        hilo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned       PROD_W    = 2 * DATA_W;
    localparam logic [DATA_W-1:0] ZERO      = '0;
    localparam logic [DATA_W-1:0] ALL_ONES  = '1;
    localparam logic [PROD_W-1:0] PROD_ZERO = '0;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              is_div;
    logic              neg_res;   // quotient/product must be negated
    logic              neg_rem;   // remainder must be negated (negative dividend)
    logic              b_zero;
    logic [DATA_W-1:0] a_lat;     // raw dividend, committed to HI on divide by zero
    logic [DATA_W-1:0] m_op;      // multiplicand magnitude or divisor magnitude
    logic [DATA_W-1:0] acc_hi;    // partial product high half / partial remainder
    logic [DATA_W-1:0] acc_lo;    // multiplier bits then product low / dividend then quotient

    // Operand magnitudes and sign bookkeeping at launch
    logic [DATA_W-1:0] a_mag_c;
    logic [DATA_W-1:0] b_mag_c;
    logic              neg_res_c;
    logic              neg_rem_c;

    always_comb begin
        a_mag_c   = a;
        b_mag_c   = b;
        neg_res_c = 1'b0;
        neg_rem_c = 1'b0;
        if (op[0]) begin
            if (a[DATA_W-1]) a_mag_c = ZERO - a;
            if (b[DATA_W-1]) b_mag_c = ZERO - b;
            neg_res_c = a[DATA_W-1] ^ b[DATA_W-1];
            neg_rem_c = op[1] & a[DATA_W-1];
        end
    end

    // One iteration: shift-add multiply step and restoring divide step
    logic [DATA_W:0] mul_sum;
    logic [DATA_W:0] div_shift;
    logic [DATA_W:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_op} : {1'b0, ZERO});
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, m_op};
    end

    // Sign correction of the raw magnitude results
    logic [PROD_W-1:0] prod_fix;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;

    always_comb begin
        prod_fix = {acc_hi, acc_lo};
        quo_fix  = acc_lo;
        rem_fix  = acc_hi;
        if (neg_res) begin
            prod_fix = PROD_ZERO - {acc_hi, acc_lo};
            quo_fix  = ZERO - acc_lo;
        end
        if (neg_rem) rem_fix = ZERO - acc_hi;
    end

    // Control FSM, datapath registers and HI/LO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            a_lat   <= '0;
            m_op    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
        end else begin
            done <= 1'b0;

            // MTHI/MTLO only while idle with no launch; independent of cancel
            if (!busy && !start) begin
                if (hilo_we[1]) hi <= wdata;
                if (hilo_we[0]) lo <= wdata;
            end

            if (cancel) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            state   <= S_RUN;
                            busy    <= 1'b1;
                            cnt     <= '0;
                            is_div  <= op[1];
                            neg_res <= neg_res_c;
                            neg_rem <= neg_rem_c;
                            b_zero  <= (b == ZERO);
                            a_lat   <= a;
                            acc_hi  <= '0;
                            if (op[1]) begin
                                acc_lo <= a_mag_c;
                                m_op   <= b_mag_c;
                            end else begin
                                acc_lo <= b_mag_c;
                                m_op   <= a_mag_c;
                            end
                        end
                    end

                    S_RUN: begin
                        if (is_div) begin
                            // Keep the difference only when it did not go negative
                            if (!div_diff[DATA_W]) acc_hi <= div_diff[DATA_W-1:0];
                            else                   acc_hi <= div_shift[DATA_W-1:0];
                            acc_lo <= {acc_lo[DATA_W-2:0], ~div_diff[DATA_W]};
                        end else begin
                            {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
                        end
                        if (cnt == LAST_CNT) state <= S_FIX;
                        else                 cnt   <= cnt + CNT_ONE;
                    end

                    S_FIX: begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        if (is_div) begin
                            if (b_zero) begin
                                lo   <= ALL_ONES;
                                hi   <= a_lat;
                                div0 <= 1'b1;
                            end else begin
                                lo   <= quo_fix;
                                hi   <= rem_fix;
                                div0 <= 1'b0;
                            end
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end

                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a 32-bit instance driven from a vector table,
// random vectors against a reference model, and hand-written cancel/HI-LO sequences.
// An 8-bit instance covers the short-latency case and the asynchronous reset.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic [1:0]   hilo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    logic         rst8;
    logic         start8;
    logic [1:0]   op8;
    logic [7:0]   a8;
    logic [7:0]   b8;
    logic         cancel8;
    logic [1:0]   hilo_we8;
    logic [7:0]   wdata8;
    logic         busy8;
    logic         done8;
    logic         div0_8;
    logic [7:0]   hi8;
    logic [7:0]   lo8;

    muldiv_unit #(.DATA_W(32), .CNT_W(6)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .hilo_we(hilo_we), .wdata(wdata),
        .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.DATA_W(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
        .cancel(cancel8), .hilo_we(hilo_we8), .wdata(wdata8),
        .busy(busy8), .done(done8), .div0(div0_8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
    } vec_t;

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    exp_t         t_e;
    vec_t         tbl[12];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] cur_hi;
    logic [W-1:0] cur_lo;
    logic         cur_d0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    // Reference model built on the simulator's own 64-bit arithmetic
    function automatic void model(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                                  input logic d0_in, output logic [W-1:0] eh, output logic [W-1:0] el,
                                  output logic ed);
        logic signed [63:0] sa, sbv, sres, srem;
        logic [63:0]        ures;
        ed = d0_in;
        sa  = {{32{xa[31]}}, xa};
        sbv = {{32{xb[31]}}, xb};
        eh  = '0;
        el  = '0;
        case (o)
            2'b00: begin
                ures = {32'h0, xa} * {32'h0, xb};
                eh = ures[63:32];
                el = ures[31:0];
            end
            2'b01: begin
                sres = sa * sbv;
                eh = sres[63:32];
                el = sres[31:0];
            end
            default: begin
                if (xb == '0) begin
                    el = '1;
                    eh = xa;
                    ed = 1'b1;
                end else if (o == 2'b10) begin
                    el = xa / xb;
                    eh = xa % xb;
                    ed = 1'b0;
                end else begin
                    sres = sa / sbv;
                    srem = sa % sbv;
                    el = sres[31:0];
                    eh = srem[31:0];
                    ed = 1'b0;
                end
            end
        endcase
    endfunction

    // Scoreboard: every done pulse retires the oldest expected result
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 with no operation pending, required done=0");
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, ".hi"},   64'(hi),   64'(mon_e.hi));
                check({mon_e.tag, ".lo"},   64'(lo),   64'(mon_e.lo));
                check({mon_e.tag, ".div0"}, 64'(div0), 64'(mon_e.div0));
            end
        end
    end

    // Launch one operation at a negedge and wait (bounded) for it to retire
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic ed);
        exp_t e;
        int   c;
        e.tag = tag; e.hi = eh; e.lo = el; e.div0 = ed;
        sb.push_back(e);
        op = o; a = xa; b = xb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        check({tag, ".idle_cycle"}, 64'(c), 64'(W + 3));
        check({tag, ".done_seen"}, 64'(sb.size()), 64'd0);
        if (sb.size() != 0) sb.delete();
        cur_hi = eh; cur_lo = el; cur_d0 = ed;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb, eh, el;
        logic         ed;
        logic         saw_done;

        tbl[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        tbl[4]  = '{2'b00, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b1};
        tbl[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[6]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        tbl[7]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        tbl[8]  = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        tbl[9]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[10] = '{2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        tbl[11] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

        rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0; hilo_we = '0; wdata = '0;
        rst8 = 1'b0; start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; cancel8 = 1'b0; hilo_we8 = '0; wdata8 = '0;
        cur_hi = '0; cur_lo = '0; cur_d0 = 1'b0;

        repeat (2) @(negedge clk);
        check("reset.hi",   64'(hi),   64'd0);
        check("reset.lo",   64'(lo),   64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.div0", 64'(div0), 64'd0);
        rst = 1'b1; rst8 = 1'b1;
        @(negedge clk);

        // Cycle-exact busy/done profile for a full-width MULTU
        t_e.tag = "t1"; t_e.hi = 32'hFFFFFFFE; t_e.lo = 32'h00000001; t_e.div0 = 1'b0;
        sb.push_back(t_e);
        op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            check($sformatf("t1.busy_c%0d", c), 64'(busy), 64'(c <= 34));
            check($sformatf("t1.done_c%0d", c), 64'(done), 64'(c == 34));
            if (c < 35) @(negedge clk);
        end
        if (sb.size() != 0) begin
            check("t1.done_seen", 64'(sb.size()), 64'd0);
            sb.delete();
        end

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].div0);
        end

        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) rb = '0;
            if (i % 7 == 3) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            if (i % 4 == 1) rb = 32'($urandom_range(1, 20));
            model(ro, ra, rb, cur_d0, eh, el, ed);
            run_op($sformatf("rnd%0d", i), ro, ra, rb, eh, el, ed);
        end

        // Clear div0 so the FIX-cancel test can see a suppressed update
        run_op("divu9_3", 2'b10, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

        // Cancel mid-RUN; a start pulse while busy is ignored
        op = 2'b00; a = 32'h00001111; b = 32'h00002222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 2'b10; a = 32'h5; b = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_run.busy", 64'(busy), 64'd0);
        check("cancel_run.hi",   64'(hi),   64'(cur_hi));
        check("cancel_run.lo",   64'(lo),   64'(cur_lo));
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("cancel_run.no_activity", 64'(saw_done), 64'd0);
        check("cancel_run.div0", 64'(div0), 64'(cur_d0));

        // Cancel in FIX drops the HI/LO/div0 commit
        op = 2'b10; a = 32'h5; b = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_fix.busy", 64'(busy), 64'd0);
        check("cancel_fix.hi",   64'(hi),   64'(cur_hi));
        check("cancel_fix.lo",   64'(lo),   64'(cur_lo));
        check("cancel_fix.div0", 64'(div0), 64'(cur_d0));
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("cancel_fix.no_done", 64'(saw_done), 64'd0);

        // Cancel beats start in the same cycle
        op = 2'b00; a = 32'h3; b = 32'h3; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel_start.busy", 64'(busy), 64'd0);

        // MTHI/MTLO while idle
        hilo_we = 2'b11; wdata = 32'h00001234;
        @(negedge clk);
        hilo_we = 2'b00;
        check("mt_both.hi", 64'(hi), 64'h1234);
        check("mt_both.lo", 64'(lo), 64'h1234);
        hilo_we = 2'b10; wdata = 32'h0000ABCD;
        @(negedge clk);
        hilo_we = 2'b00;
        check("mthi.hi", 64'(hi), 64'hABCD);
        check("mthi.lo", 64'(lo), 64'h1234);

        // A write alongside start, and during busy, is dropped
        t_e.tag = "mt_busy_op"; t_e.hi = 32'h0; t_e.lo = 32'h6; t_e.div0 = cur_d0;
        sb.push_back(t_e);
        op = 2'b00; a = 32'h2; b = 32'h3; start = 1'b1; hilo_we = 2'b11; wdata = 32'h5555;
        @(negedge clk);
        start = 1'b0;
        check("mt_start.busy", 64'(busy), 64'd1);
        check("mt_start.hi",   64'(hi),   64'hABCD);
        check("mt_start.lo",   64'(lo),   64'h1234);
        @(negedge clk);
        hilo_we = 2'b00;
        check("mt_busy.hi", 64'(hi), 64'hABCD);
        check("mt_busy.lo", 64'(lo), 64'h1234);
        begin
            int c;
            c = 2;
            while (busy && c < 200) begin
                @(negedge clk);
                c++;
            end
            check("mt_busy_op.idle_cycle", 64'(c), 64'(W + 3));
        end
        check("mt_busy_op.done_seen", 64'(sb.size()), 64'd0);
        if (sb.size() != 0) sb.delete();

        // 8-bit instance: short latency profile
        op8 = 2'b00; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            check($sformatf("w8.busy_c%0d", c), 64'(busy8), 64'(c <= 10));
            check($sformatf("w8.done_c%0d", c), 64'(done8), 64'(c == 10));
            if (c == 10) begin
                check("w8.hi", 64'(hi8), 64'hFE);
                check("w8.lo", 64'(lo8), 64'h01);
            end
            if (c < 11) @(negedge clk);
        end

        // 8-bit instance: asynchronous reset mid-RUN
        op8 = 2'b00; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst8 = 1'b0;
        #1;
        check("w8_rst.busy", 64'(busy8),  64'd0);
        check("w8_rst.done", 64'(done8),  64'd0);
        check("w8_rst.hi",   64'(hi8),    64'd0);
        check("w8_rst.lo",   64'(lo8),    64'd0);
        check("w8_rst.div0", 64'(div0_8), 64'd0);
        @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
